// File: rtl/poly_axis_tx_pkg.sv
// Shared constants and state type for the polynomial AXI4-Stream transmitter.
package poly_axis_tx_pkg;

    localparam int STORE_WIDTH     = 16;
    localparam int COEFF_WIDTH     = 12;
    localparam int COEFFS_PER_BEAT = 16;
    localparam int DWIDTH          = COEFFS_PER_BEAT * STORE_WIDTH;
    localparam int KEEP_WIDTH      = DWIDTH / 8;
    localparam int BEATS_PER_POLY  = 16;
    localparam int Q               = 3329;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } tx_state_t;

endpackage

// File: rtl/poly_axis_skid_fifo.sv
// Small circular FIFO holding output beats (data plus tlast) between RAM capture and the stream port.
module poly_axis_skid_fifo #(
    parameter int WIDTH = 257,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);

endmodule

// File: rtl/poly_axis_tx.sv
// Reads one polynomial from a beat-wide RAM and streams it as AXI4-Stream beats with TLAST.
// Optional POLY_AXIS_TX_REDUCE_EN: conditional subtract of Q on every lane at capture.
module poly_axis_tx
    import poly_axis_tx_pkg::*;
#(
    parameter int DWIDTH    = 256,
    parameter int BEATS     = 16,
    parameter int ADDR_W    = 4,
    parameter int BUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DWIDTH-1:0]     rd_data,
    output logic [DWIDTH-1:0]     m_axis_tdata,
    output logic [DWIDTH/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int OCC_W = $clog2(BUF_DEPTH + 1) + 1;

    tx_state_t         state;
    logic [CNT_W-1:0]  reads_issued;
    logic [CNT_W-1:0]  beats_captured;
    logic              vld_p1;
    logic [OCC_W-2:0]  fifo_count;
    logic              fifo_empty;
    logic [DWIDTH:0]   fifo_head;
    logic [DWIDTH:0]   push_data_p1;
    logic              pop;
    logic [OCC_W-1:0]  occ_after;

    function automatic logic [DWIDTH-1:0] reduce_beat(input logic [DWIDTH-1:0] raw);
        logic [DWIDTH-1:0] res;
`ifdef POLY_AXIS_TX_REDUCE_EN
        logic [STORE_WIDTH-1:0] v;
        res = raw;
        // Inputs up to 2Q-1 need 13 bits, so the whole storage lane is compared.
        for (int i = 0; i < DWIDTH / STORE_WIDTH; i++) begin
            v = raw[i*STORE_WIDTH +: STORE_WIDTH];
            if (v >= STORE_WIDTH'(Q)) v = v - STORE_WIDTH'(Q);
            res[i*STORE_WIDTH +: STORE_WIDTH] = {{(STORE_WIDTH-COEFF_WIDTH){1'b0}}, v[COEFF_WIDTH-1:0]};
        end
`else
        res = raw;
`endif
        return res;
    endfunction

    assign pop = m_axis_tvalid && m_axis_tready;

    // Credit counts the beat leaving this cycle, which is what lets a 2-deep buffer sustain one beat per cycle.
    assign occ_after = OCC_W'(fifo_count) + OCC_W'(vld_p1) - OCC_W'(pop);
    assign rd_en     = (state == STREAM) && (reads_issued < CNT_W'(BEATS))
                       && (occ_after < OCC_W'(BUF_DEPTH));

    // Capture stage: RAM data arrives one cycle after the read strobe.
    assign push_data_p1 = {(beats_captured == CNT_W'(BEATS - 1)), reduce_beat(rd_data)};

    poly_axis_skid_fifo #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_p1),
        .push_data (push_data_p1),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_head[DWIDTH-1:0];
    assign m_axis_tlast  = fifo_head[DWIDTH] && m_axis_tvalid;
    assign m_axis_tkeep  = m_axis_tvalid ? '1 : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            reads_issued   <= '0;
            beats_captured <= '0;
            vld_p1         <= 1'b0;
            rd_addr        <= '0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en) begin
                reads_issued <= reads_issued + CNT_W'(1);
                if (rd_addr != ADDR_W'(BEATS - 1)) rd_addr <= rd_addr + ADDR_W'(1);
            end
            if (vld_p1) beats_captured <= beats_captured + CNT_W'(1);

            case (state)
                IDLE: begin
                    done           <= 1'b0;
                    reads_issued   <= '0;
                    beats_captured <= '0;
                    rd_addr        <= '0;
                    if (start) begin
                        state <= STREAM;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (pop && m_axis_tlast) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    rd_addr <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_axis_tx.sv
// Self-checking bench for poly_axis_tx: per-cycle behavioural model plus literal latency/data pins.
module tb_poly_axis_tx;
    localparam int DW = 256;
    localparam int NB = 16;
    localparam int QV = 3329;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, rd_en;
    logic [3:0]    rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] tdata;
    logic [31:0]   tkeep;
    logic          tvalid, tlast;
    logic          tready = 1'b0;

    always #5 clk = ~clk;

    poly_axis_tx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast)
    );

    logic [DW-1:0] ram [NB];
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: 0 idle, 1 streaming, 2 done cycle.
    int ms = 0, reads_m = 0, occ_m = 0, infl_m = 0, beat_m = 0;
    int hs_total = 0, dut_dones = 0, start_cyc = 0, first_valid_cyc = -1, done_cyc = 0;
    logic [DW-1:0] exp_b [NB];
    logic [DW-1:0] got [NB];
    logic [DW-1:0] prev_data = '0;
    bit prev_stall = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] raw);
        logic [DW-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            v = int'(raw[16*i +: 16]);
`ifdef POLY_AXIS_TX_REDUCE_EN
            v = v % QV;
`endif
            r[16*i +: 16] = 16'(v);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
`ifdef POLY_AXIS_TX_REDUCE_EN
            r[16*i +: 16] = 16'($urandom_range(0, 2*QV-1));
`else
            r[16*i +: 16] = 16'($urandom);
`endif
        end
        return r;
    endfunction

    always @(negedge clk) begin
        bit exp_valid, hs, exp_rd;
        if (!rst_n) begin
            ms = 0; reads_m = 0; occ_m = 0; infl_m = 0; beat_m = 0; prev_stall = 0;
        end else begin
            exp_valid = (occ_m > 0);
            hs        = exp_valid && tready;
            exp_rd    = (ms == 1) && (reads_m < NB) && ((occ_m + infl_m - int'(hs)) < 2);
            chk("tvalid", tvalid, exp_valid);
            chk("tkeep", tkeep, exp_valid ? 32'hFFFF_FFFF : 32'h0);
            chk("busy", busy, ms == 1);
            chk("done", done, ms == 2);
            chk("rd_en", rd_en, exp_rd);
            if (exp_rd) chk("rd_addr", rd_addr, reads_m);
            if (ms == 0) chk("rd_addr_idle", rd_addr, 0);
            if (exp_valid && beat_m < NB) begin
                chk("tdata", tdata, exp_b[beat_m]);
                chk("tlast", tlast, beat_m == NB-1);
                if (prev_stall) chk("tdata_stable", tdata, prev_data);
                if (beat_m == 0 && first_valid_cyc < 0) first_valid_cyc = cyc;
            end else begin
                chk("tlast_idle", tlast, 0);
            end
            if (done) begin
                dut_dones++;
                done_cyc = cyc;
            end
            prev_stall = exp_valid && !tready;
            prev_data  = tdata;
            if (hs && beat_m < NB) begin
                got[beat_m] = tdata;
                beat_m++;
                hs_total++;
            end
            occ_m   = occ_m + infl_m - int'(hs);
            infl_m  = int'(exp_rd);
            reads_m = reads_m + int'(exp_rd);
            case (ms)
                0: if (start) begin
                    ms = 1; reads_m = 0; beat_m = 0; start_cyc = cyc;
                    for (int b = 0; b < NB; b++) exp_b[b] = model_beat(ram[b]);
                end
                1: if (hs && beat_m == NB) ms = 2;
                default: ms = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ready(input int mode, input int k);
        case (mode)
            0: tready = 1'b1;
            1: tready = ((k % 4) == 0) || ((k % 4) == 3);
            default: tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic send_poly(input int mode, input int stray_at, input bit start_at_done);
        int k, d0;
        d0 = dut_dones;
        first_valid_cyc = -1;
        hs_total = 0;
        start = 1'b1;
        drive_ready(mode, 0);
        step();
        start = 1'b0;
        k = 1;
        while (!done && k < 400) begin
            drive_ready(mode, k);
            start = (k == stray_at);
            step();
            k++;
        end
        chk("done_seen", done, 1);
        start = start_at_done;
        step();
        start = 1'b0;
        chk("beats_per_poly", hs_total, NB);
        chk("one_done", dut_dones - d0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < 16; i++) ram[b][16*i +: 16] = 16'(16*b + i);
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tkeep", tkeep, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_tlast", tlast, 0);
        step();

        // Full throughput with counting pattern
        send_poly(0, -1, 0);
        chk("first_valid_latency", first_valid_cyc - start_cyc, 3);
        chk("done_latency", done_cyc - start_cyc, 19);
        chk("beat5_lane3", got[5][63:48], 16'h0053);
        chk("beat15_lane15", got[15][255:240], 16'h00FF);
        chk("beat0_lane0", got[0][15:0], 16'h0000);

        // Backpressure 1,0,0,1
        for (int b = 0; b < NB; b++) ram[b] = rand_beat();
        send_poly(1, -1, 0);

        // Stray start while busy
        send_poly(0, 8, 0);
        repeat (3) step();
        chk("stray_start_idle", busy, 0);

        // Start during the done cycle must be ignored
        send_poly(2, -1, 1);
        repeat (3) step();
        chk("b2b_start_ignored", busy, 0);

        // Reset after beat 7 handshake
        begin
            int k, d0;
            for (int b = 0; b < NB; b++) ram[b] = rand_beat();
            start = 1'b1;
            tready = 1'b1;
            step();
            start = 1'b0;
            k = 0;
            while (beat_m < 8 && k < 100) begin
                step();
                k++;
            end
            chk("reached_beat8", beat_m, 8);
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            chk("midrst_tvalid", tvalid, 0);
            chk("midrst_busy", busy, 0);
            chk("midrst_done", done, 0);
            d0 = dut_dones;
            repeat (6) step();
            chk("midrst_no_done", dut_dones - d0, 0);
        end
        send_poly(2, -1, 0);

        // Random polynomials, random ready
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < NB; b++) ram[b] = rand_beat();
            send_poly(2, -1, 0);
        end

        // Reduction boundary values
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < 16; i++)
                ram[b][16*i +: 16] = (i % 3 == 0) ? 16'd3328 : (i % 3 == 1) ? 16'd3329 : 16'd6657;
        send_poly(0, -1, 0);
`ifdef POLY_AXIS_TX_REDUCE_EN
        chk("reduce_lane0", got[0][15:0], 16'd3328);
        chk("reduce_lane1", got[0][31:16], 16'd0);
        chk("reduce_lane2", got[0][47:32], 16'd3328);
`else
        chk("pass_lane0", got[0][15:0], 16'd3328);
        chk("pass_lane1", got[0][31:16], 16'd3329);
        chk("pass_lane2", got[0][47:32], 16'd6657);
`endif

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
